wb_regfile: RTL and testbench

//  Writeback stage plus architectural register file; consumes the MEM/WB pipeline register outputs.
//  - Selects writeback data: memory data for loads, ALU result otherwise.
//  - Writes the 8x16 register file and serves two decode-stage read ports.
//  - Keeps a one-deep last-write record for the forwarding unit and a retired-writeback counter.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/regfile_2r1w.sv | 50 +++++
 rtl/wb_regfile.sv | 116 +++++++++++
 tb/tb_wb_regfile.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU pipeline types and widths. Used by the writeback/register-file
//   slice and by the MEM/WB pipeline register that feeds it.
//   Contents:
//     DATA_W, ADDR_W, CNT_W : default data, register-address and counter widths
//     reg_addr_t            : register address (ADDR_W bits)
//     word_t                : data word (DATA_W bits)
//     wb_bundle_t           : MEM/WB fields consumed by the writeback stage
//     wb_select()           : load/ALU writeback data selection
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef struct packed {
    word_t     mem_data;
    word_t     alu_result;
    reg_addr_t rdst;
    logic      mem_read;
    logic      wb_en;
  } wb_bundle_t;

  // Loads write back memory data; everything else writes back the ALU result.
  function automatic word_t wb_select(input wb_bundle_t b);
    return b.mem_read ? b.mem_data : b.alu_result;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//   2**ADDR_W x DATA_W register array, one synchronous write port and two
//   combinational read ports. No write-to-read bypass: a write becomes visible
//   on the read ports after the clock edge that performs it.
//   Ports:
//     clk        : clock, writes on posedge
//     rst_n      : asynchronous active-low reset, clears every entry
//     i_we       : write enable
//     i_waddr    : write address
//     i_wdata    : write data
//     i_raddr_a  : read port A address
//     i_raddr_b  : read port B address
//     o_rdata_a  : read port A data
//     o_rdata_b  : read port B data
// -----------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [NREG];

  // Every entry, R0 included, is an ordinary writable register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage plus architectural register file. Consumes MEM/WB outputs,
//   selects load data or ALU result, writes the register file, serves two
//   decode read ports, and keeps a one-deep last-write record for the
//   forwarding unit together with a retired-writeback counter.
//   Build option:
//     WB_BYPASS_EN : when defined, a read whose address matches the register
//                    being written this cycle returns the incoming writeback
//                    data (same-cycle write-through). When undefined, reads
//                    return the array only and hazards are covered via fwd_*.
//   Ports:
//     clk, rst_n         : clock (posedge), asynchronous active-low reset
//     wb_mem_data        : load data from MEM/WB
//     wb_alu_result      : ALU result from MEM/WB
//     wb_rdst            : destination register
//     wb_mem_read        : 1 = write load data, 0 = write ALU result
//     wb_en              : writeback enable
//     rd_addr_a/b        : decode read addresses
//     rd_data_a/b        : decode read data (combinational)
//     fwd_valid/addr/data: record of the write performed at the last posedge
//     retire_cnt         : number of completed writebacks (wraps)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [ADDR_W-1:0] wb_rdst,
  input  logic              wb_mem_read,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_arr_a;
  logic [DATA_W-1:0] w_arr_b;

  logic              r_fwd_valid;
  logic [ADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0] r_fwd_data;
  logic [CNT_W-1:0]  r_retire_cnt;

  assign w_wb_data = wb_mem_read ? wb_mem_data : wb_alu_result;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (wb_en),
    .i_waddr   (wb_rdst),
    .i_wdata   (w_wb_data),
    .i_raddr_a (rd_addr_a),
    .i_raddr_b (rd_addr_b),
    .o_rdata_a (w_arr_a),
    .o_rdata_b (w_arr_b)
  );

`ifdef WB_BYPASS_EN
  // Write-through is suppressed while reset is held: a write presented during
  // reset never lands, so it must not be visible on the read ports either.
  logic w_byp_a;
  logic w_byp_b;
  assign w_byp_a   = rst_n && wb_en && (rd_addr_a == wb_rdst);
  assign w_byp_b   = rst_n && wb_en && (rd_addr_b == wb_rdst);
  assign rd_data_a = w_byp_a ? w_wb_data : w_arr_a;
  assign rd_data_b = w_byp_b ? w_wb_data : w_arr_b;
`else
  assign rd_data_a = w_arr_a;
  assign rd_data_b = w_arr_b;
`endif

  // Last-write record: valid tracks wb_en every cycle, while address and data
  // hold the most recent real write so the forwarding unit can still see them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_fwd_valid <= wb_en;
      if (wb_en) begin
        r_fwd_addr <= wb_rdst;
        r_fwd_data <= w_wb_data;
      end
    end
  end

  // Free-running modulo counter of completed writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (wb_en) begin
      r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign fwd_valid  = r_fwd_valid;
  assign fwd_addr   = r_fwd_addr;
  assign fwd_data   = r_fwd_data;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile. Inputs change on the falling edge;
//   combinational reads are sampled before the rising edge, registered outputs
//   #1 after it. A reference model (register array, last-write record, modulo
//   counter) is updated at each rising edge from the inputs present there.
//   Follows WB_BYPASS_EN for same-cycle read expectations.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;
  localparam int NREG   = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] wb_mem_data = '0;
  logic [DATA_W-1:0] wb_alu_result = '0;
  logic [ADDR_W-1:0] wb_rdst = '0;
  logic              wb_mem_read = 1'b0;
  logic              wb_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr_a = '0;
  logic [ADDR_W-1:0] rd_addr_b = '0;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  retire_cnt;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_mem_data   (wb_mem_data),
    .wb_alu_result (wb_alu_result),
    .wb_rdst       (wb_rdst),
    .wb_mem_read   (wb_mem_read),
    .wb_en         (wb_en),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .retire_cnt    (retire_cnt)
  );

  // ---------------- reference model / scoreboard ----------------
  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] m_rf [NREG];
  logic              m_fv;
  logic [ADDR_W-1:0] m_fa;
  logic [DATA_W-1:0] m_fd;
  int unsigned       m_cnt;
  logic [DATA_W-1:0] exp_q[$];

  function automatic logic [DATA_W-1:0] sel_data();
    return wb_mem_read ? wb_mem_data : wb_alu_result;
  endfunction

  // Value a decode read at addr should show right now (before the edge).
  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] addr);
`ifdef WB_BYPASS_EN
    if (rst_n && wb_en && addr == wb_rdst) return sel_data();
`endif
    return m_rf[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_fv  = 1'b0;
    m_fa  = '0;
    m_fd  = '0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  // Called just after a rising edge with reset released.
  task automatic model_edge();
    m_fv = wb_en;
    if (wb_en) begin
      m_rf[wb_rdst] = sel_data();
      m_fa  = wb_rdst;
      m_fd  = sel_data();
      m_cnt = (m_cnt + 1) % 65536;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic mr, input logic [DATA_W-1:0] mem,
                       input logic [DATA_W-1:0] alu, input logic [ADDR_W-1:0] rdst);
    @(negedge clk);
    wb_en = en; wb_mem_read = mr; wb_mem_data = mem; wb_alu_result = alu; wb_rdst = rdst;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Put some state in first, then reset with a write pending on R3.
    drive(1'b1, 1'b0, 16'h0, 16'h4321, 3'd1);
    step();
    drive(1'b1, 1'b0, 16'h0, 16'h1111, 3'd3);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int a = 0; a < NREG; a++) begin
      rd_addr_a = a[ADDR_W-1:0];
      #1;
      checks++;
      if (rd_data_a !== 16'h0) begin
        errors++; $display("FAIL reset_rd_a[%0d] got=%h exp=0000", a, rd_data_a);
      end
    end
    checks++;
    if (fwd_valid !== 1'b0 || fwd_addr !== 3'd0 || fwd_data !== 16'h0) begin
      errors++; $display("FAIL reset_fwd got=%b/%0d/%h exp=0/0/0000", fwd_valid, fwd_addr, fwd_data);
    end
    checks++;
    if (retire_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", retire_cnt);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    rst_n = 1'b1;
    step();
    rd_addr_a = 3'd3; rd_addr_b = 3'd1;
    #1;
    checks++;
    if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
      errors++; $display("FAIL reset_discard R3=%h R1=%h exp=0000/0000", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b0, 16'hFFFF, 16'h1234, 3'd5);
    step();
    rd_addr_a = 3'd5;
    #1;
    checks++;
    if (rd_data_a !== 16'h1234) begin
      errors++; $display("FAIL alu_rd got=%h exp=1234", rd_data_a);
    end
    checks++;
    if (fwd_valid !== 1'b1 || fwd_addr !== 3'd5 || fwd_data !== 16'h1234) begin
      errors++; $display("FAIL alu_fwd got=%b/%0d/%h exp=1/5/1234", fwd_valid, fwd_addr, fwd_data);
    end
    checks++;
    if (retire_cnt !== 16'd1) begin
      errors++; $display("FAIL alu_cnt got=%0d exp=1", retire_cnt);
    end
  endtask

  task automatic test_load_write();
    drive(1'b1, 1'b1, 16'hBEEF, 16'h0001, 3'd2);
    step();
    rd_addr_b = 3'd2;
    #1;
    checks++;
    if (rd_data_b !== 16'hBEEF) begin
      errors++; $display("FAIL load_rd got=%h exp=beef", rd_data_b);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    step();
    checks++;
    if (fwd_valid !== 1'b0 || fwd_addr !== 3'd2 || fwd_data !== 16'hBEEF) begin
      errors++; $display("FAIL load_fwd_hold got=%b/%0d/%h exp=0/2/beef", fwd_valid, fwd_addr, fwd_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [DATA_W-1:0] exp_now;
`ifdef WB_BYPASS_EN
    exp_now = 16'hA5A5;
`else
    exp_now = 16'h0000;
`endif
    drive(1'b1, 1'b0, 16'h0, 16'hA5A5, 3'd7);
    rd_addr_a = 3'd7; rd_addr_b = 3'd7;
    #2;
    checks++;
    if (rd_data_a !== exp_now || rd_data_b !== exp_now) begin
      errors++; $display("FAIL same_cycle_rd got=%h/%h exp=%h", rd_data_a, rd_data_b, exp_now);
    end
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    #1;
    checks++;
    if (rd_data_a !== 16'hA5A5 || rd_data_b !== 16'hA5A5) begin
      errors++; $display("FAIL same_cycle_next got=%h/%h exp=a5a5", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_disabled();
    logic [DATA_W-1:0] r4_before;
    int unsigned       cnt_before;
    r4_before  = m_rf[4];
    cnt_before = m_cnt;
    drive(1'b0, 1'b0, 16'h0, 16'h5555, 3'd4);
    step();
    rd_addr_a = 3'd4;
    #1;
    checks++;
    if (rd_data_a !== r4_before) begin
      errors++; $display("FAIL disabled_r4 got=%h exp=%h", rd_data_a, r4_before);
    end
    checks++;
    if (retire_cnt !== cnt_before[CNT_W-1:0] || fwd_valid !== 1'b0) begin
      errors++; $display("FAIL disabled_state cnt=%0d fv=%b exp=%0d/0", retire_cnt, fwd_valid, cnt_before);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] e;
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF),
            $urandom_range(0, NREG-1));
      rd_addr_a = $urandom_range(0, NREG-1);
      rd_addr_b = (n % 4 == 0) ? rd_addr_a : $urandom_range(0, NREG-1);
      #1;
      checks++;
      if (rd_data_a !== exp_read(rd_addr_a) || rd_data_b !== exp_read(rd_addr_b)) begin
        errors++;
        $display("FAIL rand_rd n=%0d a[%0d]=%h b[%0d]=%h exp=%h/%h", n, rd_addr_a, rd_data_a,
                 rd_addr_b, rd_data_b, exp_read(rd_addr_a), exp_read(rd_addr_b));
      end
      if (wb_en) exp_q.push_back(sel_data());
      step();
      checks++;
      if (fwd_valid !== m_fv || fwd_addr !== m_fa || retire_cnt !== m_cnt[CNT_W-1:0]) begin
        errors++;
        $display("FAIL rand_state n=%0d fv=%b fa=%0d cnt=%0d exp=%b/%0d/%0d", n, fwd_valid,
                 fwd_addr, retire_cnt, m_fv, m_fa, m_cnt);
      end
      if (m_fv) begin
        e = exp_q.pop_front();
        checks++;
        if (fwd_data !== e) begin
          errors++; $display("FAIL rand_fwd_data n=%0d got=%h exp=%h", n, fwd_data, e);
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    int unsigned need;
    need = 65535 - m_cnt;
    drive(1'b1, 1'b0, 16'h0, 16'h0F0F, 3'd6);
    repeat (need) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    checks++;
    if (retire_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL cnt_max got=%h exp=ffff", retire_cnt);
    end
    step();
    checks++;
    if (retire_cnt !== 16'h0000 || m_cnt != 0) begin
      errors++; $display("FAIL cnt_wrap got=%h exp=0000", retire_cnt);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    step();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_alu_write();
    test_load_write();
    test_same_cycle();
    test_disabled();
    test_random();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
